// File: rtl/mmem_ctl.sv
// M-memory access controller: arbitrates RAM ports A (read) and B (write) between the
// CPU pipeline and the spy interface, with same-cycle write bypass and bounded spy starvation.
module mmem_ctl #(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_radr,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_wadr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          spy_req,
    input  logic          spy_we,
    input  logic [AW-1:0] spy_adr,
    input  logic [DW-1:0] spy_wdata,
    output logic          spy_ack,
    output logic [DW-1:0] spy_rdata,
    output logic          ram_rden,
    output logic [AW-1:0] ram_radr,
    input  logic [DW-1:0] ram_q,
    output logic          ram_wren,
    output logic [AW-1:0] ram_wadr,
    output logic [DW-1:0] ram_wdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          spy_we_q;
    logic [AW-1:0] spy_adr_q;
    logic [DW-1:0] spy_wdata_q;
    logic [DW-1:0] spy_rdata_q;
    logic          rd_cpu_q;
    logic          byp_hit_q;
    logic [DW-1:0] byp_data_q;

    logic          cpu_rd_acc;
    logic          cpu_wr_acc;
    logic          spy_grant;
    logic          spy_rd_go;
    logic          spy_wr_go;
    logic          byp_hit;
    logic [DW-1:0] rd_data;

    // Nothing reaches the RAM during reset; a stalled CPU request is dropped.
    assign cpu_rd_acc = cpu_rd & ~cpu_stall & ~reset;
    assign cpu_wr_acc = cpu_wr & ~cpu_stall & ~reset;
    assign spy_grant  = (state == WAIT) & ~reset &
                        (cpu_stall | (spy_we_q ? ~cpu_wr : ~cpu_rd));
    assign spy_rd_go  = spy_grant & ~spy_we_q;
    assign spy_wr_go  = spy_grant & spy_we_q;

    assign ram_rden  = cpu_rd_acc | spy_rd_go;
    assign ram_radr  = cpu_rd_acc ? cpu_radr : (spy_rd_go ? spy_adr_q : '0);
    assign ram_wren  = cpu_wr_acc | spy_wr_go;
    assign ram_wadr  = cpu_wr_acc ? cpu_wadr : (spy_wr_go ? spy_adr_q : '0);
    assign ram_wdata = cpu_wr_acc ? cpu_wdata : (spy_wr_go ? spy_wdata_q : '0);

    // The RAM returns stale data on a read/write collision, so forward the write data instead.
    assign byp_hit   = ram_rden & ram_wren & (ram_wadr == ram_radr);
    assign rd_data   = byp_hit_q ? byp_data_q : ram_q;

    assign cpu_rdata = rd_cpu_q ? rd_data : '0;
    assign spy_rdata = (spy_ack & ~spy_we_q) ? rd_data : spy_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            cpu_stall   <= 1'b0;
            spy_ack     <= 1'b0;
            spy_rdata_q <= '0;
            rd_cpu_q    <= 1'b0;
            byp_hit_q   <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            rd_cpu_q   <= cpu_rd_acc;
            byp_hit_q  <= byp_hit;
            byp_data_q <= ram_wdata;
            cpu_stall  <= 1'b0;
            spy_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (spy_req) begin
                        spy_we_q    <= spy_we;
                        spy_adr_q   <= spy_adr;
                        spy_wdata_q <= spy_wdata;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (spy_grant) begin
                        starve_cnt <= '0;
                        spy_ack    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (starve_cnt != CW'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + CW'(1);
                        // Hitting the limit forces a one-cycle CPU stall that guarantees the grant.
                        if (starve_cnt == CW'(STARVE_LIMIT - 1))
                            cpu_stall <= 1'b1;
                    end
                end
                DONE: begin
                    if (!spy_we_q)
                        spy_rdata_q <= rd_data;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmem_ctl.sv
// Bench for mmem_ctl: directed scenarios plus random traffic against an architectural
// model in which every read observes the writes of its own cycle.
module tb_mmem_ctl;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr, spy_req, spy_we;
    logic [AW-1:0] cpu_radr, cpu_wadr, spy_adr;
    logic [DW-1:0] cpu_wdata, spy_wdata;
    logic [DW-1:0] cpu_rdata, spy_rdata, ram_q, ram_wdata;
    logic          cpu_stall, spy_ack, ram_rden, ram_wren;
    logic [AW-1:0] ram_radr, ram_wadr;

    always #5 clk = ~clk;

    mmem_ctl #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_radr(cpu_radr), .cpu_wr(cpu_wr), .cpu_wadr(cpu_wadr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .spy_req(spy_req), .spy_we(spy_we), .spy_adr(spy_adr), .spy_wdata(spy_wdata),
        .spy_ack(spy_ack), .spy_rdata(spy_rdata),
        .ram_rden(ram_rden), .ram_radr(ram_radr), .ram_q(ram_q),
        .ram_wren(ram_wren), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata)
    );

    // RAM device: synchronous read, old data on same-cycle collision
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_wadr] <= ram_wdata;
        if (ram_rden) ram_q <= ram[ram_radr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stall_seen = 0;
    int stall_at   = -1;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: architectural memory plus spy op phase (0 idle, 1 waiting, 2 acking)
    logic [DW-1:0] m_mem [32];
    int            m_phase, m_blocked;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wd;
    logic          e_stall, e_ack, e_spy_vld, e_cpu_vld;
    logic [DW-1:0] e_spy_data, e_cpu_data;

    task automatic model_step();
        logic [DW-1:0] nm [32];
        logic granted, nstall;
        if (reset) begin
            m_phase = 0; m_blocked = 0;
            e_stall = 0; e_ack = 0; e_spy_vld = 0; e_cpu_vld = 0;
            return;
        end
        nm = m_mem;
        granted = (m_phase == 1) && (e_stall || (m_we ? !cpu_wr : !cpu_rd));
        if (cpu_wr && !e_stall) nm[cpu_wadr] = cpu_wdata;
        if (granted && m_we) nm[m_adr] = m_wd;
        e_cpu_vld  = cpu_rd && !e_stall;
        e_cpu_data = nm[cpu_radr];
        e_ack      = granted;
        e_spy_vld  = granted && !m_we;
        if (e_spy_vld) e_spy_data = nm[m_adr];
        nstall = 0;
        case (m_phase)
            0: if (spy_req) begin
                m_phase = 1; m_blocked = 0; m_we = spy_we; m_adr = spy_adr; m_wd = spy_wdata;
            end
            1: if (granted) m_phase = 2;
               else begin
                   m_blocked++;
                   nstall = (m_blocked == LIM);
               end
            default: m_phase = 0;
        endcase
        e_stall = nstall;
        m_mem = nm;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cpu_stall) begin stall_seen++; stall_at = cyc; end
        check_val("stall", {31'b0, cpu_stall}, {31'b0, e_stall});
        check_val("ack", {31'b0, spy_ack}, {31'b0, e_ack});
        if (e_spy_vld) check_val("spy_rdata", spy_rdata, e_spy_data);
        if (e_cpu_vld) check_val("cpu_rdata", cpu_rdata, e_cpu_data);
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; spy_req = 0; spy_we = 0;
        cpu_radr = '0; cpu_wadr = '0; cpu_wdata = '0; spy_adr = '0; spy_wdata = '0;
    endtask

    // Issue one spy op and return cycles from request to ack (bounded)
    task automatic spy_op(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                          output int n);
        spy_req = 1; spy_we = we; spy_adr = adr; spy_wdata = wd;
        n = 0;
        do begin
            step();
            n++;
            spy_req = 0;
        end while (!spy_ack && n < 40);
        if (!spy_ack) check_val("spy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, s0;
        for (int i = 0; i < 32; i++) begin ram[i] = '0; m_mem[i] = '0; end
        ram_q = '0;
        e_stall = 0; e_ack = 0; e_spy_vld = 0; e_cpu_vld = 0;
        m_phase = 0; m_blocked = 0; m_we = 0; m_adr = '0; m_wd = '0;
        e_spy_data = '0; e_cpu_data = '0;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step(); step();
        check_val("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check_val("rst_ack", {31'b0, spy_ack}, 32'd0);
        check_val("rst_spy_rdata", spy_rdata, 32'd0);
        check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
        reset = 0;

        // Write then read back
        cpu_wr = 1; cpu_wadr = 3; cpu_wdata = 32'hDEADBEEF; step();
        cpu_wr = 0; cpu_rd = 1; cpu_radr = 3; step();
        cpu_rd = 0;
        check_val("t1_rdata", cpu_rdata, 32'hDEADBEEF);

        // Same-cycle write/read collision must forward the new data
        cpu_wr = 1; cpu_wadr = 7; cpu_wdata = 32'h11111111; step();
        cpu_wdata = 32'h12345678; cpu_rd = 1; cpu_radr = 7; step();
        idle_inputs();
        check_val("t2_bypass", cpu_rdata, 32'h12345678);

        // Spy write then read with CPU idle
        spy_op(1, 31, 32'hA5A5A5A5, n);
        check_val("t3_wr_lat", n, 2);
        step();
        spy_op(0, 31, '0, n);
        check_val("t3_rd_lat", n, 2);
        check_val("t3_rd_data", spy_rdata, 32'hA5A5A5A5);
        step();

        // Continuous CPU reads starve a spy read until the forced stall
        cpu_rd = 1; cpu_radr = 1;
        s0 = stall_seen;
        spy_op(0, 0, '0, n);
        check_val("t4_ack_lat", n, LIM + 2);
        check_val("t4_stall_cnt", stall_seen - s0, 1);
        check_val("t4_stall_pos", cyc - stall_at, 1);
        repeat (20) step();
        check_val("t4_no_restall", stall_seen - s0, 1);

        // Spy write while CPU only reads: immediate grant, no stall
        s0 = stall_seen;
        spy_op(1, 5, 32'h0BADF00D, n);
        check_val("t5_ack_lat", n, 2);
        check_val("t5_no_stall", stall_seen - s0, 0);
        idle_inputs();
        step();
        cpu_rd = 1; cpu_radr = 5; step(); cpu_rd = 0;
        check_val("t5_readback", cpu_rdata, 32'h0BADF00D);

        // Reset while a spy write is waiting on a busy write port
        cpu_wr = 1; cpu_wadr = 9; cpu_wdata = 32'h99990000;
        spy_req = 1; spy_we = 1; spy_adr = 10; spy_wdata = 32'hFFFF0000;
        step(); spy_req = 0; step();
        reset = 1;
        #1;
        check_val("t6_wren_in_rst", {31'b0, ram_wren}, 32'd0);
        cpu_wr = 0;
        step();
        check_val("t6_stall", {31'b0, cpu_stall}, 32'd0);
        check_val("t6_ack", {31'b0, spy_ack}, 32'd0);
        check_val("t6_spy_rdata", spy_rdata, 32'd0);
        check_val("t6_cpu_rdata", cpu_rdata, 32'd0);
        check_val("t6_rden", {31'b0, ram_rden}, 32'd0);
        check_val("t6_wren", {31'b0, ram_wren}, 32'd0);
        reset = 0;
        repeat (5) step();
        cpu_rd = 1; cpu_radr = 10; step(); cpu_rd = 0;
        check_val("t6_no_spy_write", cpu_rdata, 32'd0);

        // Random traffic in phases of varying CPU load
        for (int i = 0; i < 4000; i++) begin
            int load;
            load = ((i / 250) % 3 == 0) ? 20 : (((i / 250) % 3 == 1) ? 60 : 97);
            cpu_rd    = ($urandom_range(0, 99) < load);
            cpu_wr    = ($urandom_range(0, 99) < load);
            cpu_radr  = AW'($urandom_range(0, 7));
            cpu_wadr  = AW'($urandom_range(0, 7));
            cpu_wdata = $urandom;
            spy_req   = ($urandom_range(0, 99) < 30);
            spy_we    = $urandom_range(0, 1) == 1;
            spy_adr   = AW'($urandom_range(0, 7));
            spy_wdata = $urandom;
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmem_ctl.md
Name: mmem_ctl

Overview:
Access controller for the 32x32 M-memory dual-port RAM. Shares the read port (port A) and the write port (port B) between the CPU microinstruction pipeline and the spy/debug interface. Provides read-after-write bypass for the CPU and starvation-bounded grants for spy. Sits between the CPU datapath and the M-memory RAM instance.

Parameters:
AW, 5, M-memory address width (32 words).
DW, 32, data width.
STARVE_LIMIT, 15, consecutive blocked spy cycles before a forced CPU stall.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_rd  in  1  CPU read request (mrp equivalent)
cpu_radr  in  AW  CPU read address
cpu_wr  in  1  CPU write request (mwp equivalent)
cpu_wadr  in  AW  CPU write address
cpu_wdata  in  DW  CPU write data (L bus)
cpu_rdata  out  DW  CPU read data, valid the cycle after cpu_rd is accepted
cpu_stall  out  1  CPU must hold; cpu_rd/cpu_wr are ignored this cycle
spy_req  in  1  spy access request (level)
spy_we  in  1  spy write (1) / read (0), sampled with spy_req in IDLE
spy_adr  in  AW  spy address
spy_wdata  in  DW  spy write data
spy_ack  out  1  one-cycle completion pulse
spy_rdata  out  DW  spy read data, valid while spy_ack=1
ram_rden  out  1  RAM port A read enable
ram_radr  out  AW  RAM port A address
ram_q  in  DW  RAM port A data (1-cycle synchronous read)
ram_wren  out  1  RAM port B write enable
ram_wadr  out  AW  RAM port B address
ram_wdata  out  DW  RAM port B data

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, starve counter=0, cpu_stall=0, spy_ack=0, spy_rdata=0, cpu_rdata bypass registers cleared, ram_rden=ram_wren=0.
- Read port A: CPU has priority. ram_rden=cpu_rd&~cpu_stall, ram_radr=cpu_radr. Otherwise spy read drives port A when granted.
- Write port B: CPU has priority. ram_wren=cpu_wr&~cpu_stall with CPU address/data. Otherwise spy write when granted.
- Bypass: RAM returns old data on same-cycle read/write collision. If an accepted CPU read at cycle t hits the address of any write (CPU or spy) committed at cycle t, cpu_rdata at t+1 = that write data; otherwise cpu_rdata = ram_q. Latency is always 1 cycle.
- Spy FSM:
  - IDLE: on spy_req, latch we/adr/wdata and go to WAIT.
  - WAIT: the grant is free when the needed port is unused by the CPU this cycle (read: ~cpu_rd; write: ~cpu_wr), or when cpu_stall=1. On grant, issue the RAM op and go to DONE. Otherwise increment the starve counter.
  - DONE: a write pulses spy_ack. A read captures ram_q (with bypass if the CPU wrote the same address in the grant cycle) into spy_rdata and pulses spy_ack. Then go to IDLE.
- Starvation: when the counter reaches STARVE_LIMIT in WAIT, the next cycle asserts cpu_stall for exactly one cycle. The spy op is granted in that cycle and the counter clears. Worst-case spy latency is STARVE_LIMIT+2 cycles from req to ack.
- Counter saturates and never wraps; it clears on grant and on reset.
- Dropping spy_req after IDLE does not abort the op; it still completes and acks. A new request is accepted only in IDLE, so there is a minimum 1-cycle gap after the ack.
- Reset mid-operation abandons the spy op without ack; no RAM write is issued in the reset cycle.
- cpu_stall is never asserted outside the forced-grant cycle.

Test Plan:
1. CPU write addr 3 = 0xDEADBEEF, then read addr 3 next cycle -> cpu_rdata=0xDEADBEEF one cycle after the read.
2. Same-cycle CPU write addr 7 = 0x12345678 and CPU read addr 7 -> cpu_rdata=0x12345678 (bypass), not the old contents.
3. Idle CPU, spy write addr 31 = 0xA5A5A5A5, then spy read addr 31 -> write ack 2 cycles after req; read ack 2 cycles after req with spy_rdata=0xA5A5A5A5.
4. CPU reads every cycle while spy reads addr 0 -> cpu_stall high for exactly one cycle after 15 blocked cycles; spy_ack at cycle 17; cpu_stall never re-asserted.
5. CPU reads only, spy write addr 5 -> granted immediately on the write port with no stall; ack at cycle 2.
6. Assert reset while FSM is in WAIT -> no spy_ack, no ram_wren, all outputs 0 the next cycle, FSM returns to IDLE.
